// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hard-wired CPU control sequencer:
// state encoding, opcode/ALU codes, IR field positions and opcode classification.
package cpu_ctrl_pkg;

   localparam int IR_W        = 32;
   localparam int OPCODE_W    = 5;
   localparam int REG_FIELD_W = 4;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;
   localparam int RA_MSB     = 26;
   localparam int RA_LSB     = 23;
   localparam int RB_MSB     = 22;
   localparam int RB_LSB     = 19;
   localparam int RC_MSB     = 18;
   localparam int RC_LSB     = 15;

   typedef logic [OPCODE_W-1:0] opcode_t;

   localparam opcode_t OP_ADD  = 5'b00001;
   localparam opcode_t OP_SUB  = 5'b00010;
   localparam opcode_t OP_AND  = 5'b00011;
   localparam opcode_t OP_OR   = 5'b00100;
   localparam opcode_t OP_SHR  = 5'b00101;
   localparam opcode_t OP_SHL  = 5'b00110;
   localparam opcode_t OP_ROR  = 5'b00111;
   localparam opcode_t OP_ROL  = 5'b01000;
   localparam opcode_t OP_MUL  = 5'b01001;
   localparam opcode_t OP_DIV  = 5'b01010;
   localparam opcode_t OP_NEG  = 5'b01011;
   localparam opcode_t OP_NOT  = 5'b01100;
   localparam opcode_t OP_ADDI = 5'b01101;
   localparam opcode_t OP_ANDI = 5'b01110;
   localparam opcode_t OP_ORI  = 5'b01111;
   localparam opcode_t OP_NOP  = 5'b11010;
   localparam opcode_t OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RST,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALTED
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_IMM,
      CLS_UNARY,
      CLS_MULDIV,
      CLS_NOP,
      CLS_HALT
   } op_class_t;

   // Unrecognised opcodes fall into CLS_NOP so they simply skip execution.
   function automatic op_class_t classify(input opcode_t op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: classify = CLS_RTYPE;
         OP_ADDI, OP_ANDI, OP_ORI:       classify = CLS_IMM;
         OP_NEG, OP_NOT:                 classify = CLS_UNARY;
         OP_MUL, OP_DIV:                 classify = CLS_MULDIV;
         OP_HALT:                        classify = CLS_HALT;
         default:                        classify = CLS_NOP;
      endcase
   endfunction

   function automatic opcode_t alu_code(input opcode_t op);
      case (op)
         OP_ADDI: alu_code = OP_ADD;
         OP_ANDI: alu_code = OP_AND;
         OP_ORI:  alu_code = OP_OR;
         default: alu_code = op;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle between the sequencer (master) and CPU_Datapath (slave).
interface control_sequencer_if #(
   parameter int NREGS    = 16,
   parameter int ALUSEL_W = 5
);
   logic [31:0]         ir;
   logic [NREGS-1:0]    rin;
   logic [NREGS-1:0]    rout;
   logic                pc_out;
   logic                pc_in;
   logic                inc_pc;
   logic                mar_in;
   logic                mdr_in;
   logic                mdr_out;
   logic                read;
   logic                ir_in;
   logic                y_in;
   logic                z_in;
   logic                zlo_in;
   logic                zhi_in;
   logic                zlo_out;
   logic                zhi_out;
   logic                hi_in;
   logic                lo_in;
   logic                c_out;
   logic [ALUSEL_W-1:0] alu_sel;
   logic                run;

   modport master (
      input  ir,
      output rin, rout, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in,
             y_in, z_in, zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in, c_out,
             alu_sel, run
   );

   modport slave (
      output ir,
      input  rin, rout, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in,
             y_in, z_in, zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in, c_out,
             alu_sel, run
   );
endinterface

// File: rtl/reg_select_decoder.sv
// Register-field to one-hot enable decoder; all outputs low when en is low.
module reg_select_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int NREGS = 16
) (
   input  logic [REG_FIELD_W-1:0] sel,
   input  logic                   en,
   output logic [NREGS-1:0]       onehot
);
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
         assign onehot[gi] = en && (sel == REG_FIELD_W'(gi));
      end
   endgenerate
endmodule

// File: rtl/control_sequencer.sv
// Hard-wired control unit: sequences fetch (T0-T2) and execute (T3-T6) strobes
// for CPU_Datapath. Outputs are Moore, decoded from the state register and IR.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NREGS    = 16,
   parameter int ALUSEL_W = 5
) (
   input  logic clk,
   input  logic clr,
   control_sequencer_if.master bus
);

   state_t                 state_reg;
   opcode_t                opcode;
   op_class_t              op_class;
   logic [REG_FIELD_W-1:0] ra;
   logic [REG_FIELD_W-1:0] rb;
   logic [REG_FIELD_W-1:0] rc;
   logic [REG_FIELD_W-1:0] rout_sel;
   logic                   rout_en;
   logic                   rin_en;
   logic                   alu_en;
   logic                   unused_ir_bits;

   assign opcode         = bus.ir[OPCODE_MSB:OPCODE_LSB];
   assign ra             = bus.ir[RA_MSB:RA_LSB];
   assign rb             = bus.ir[RB_MSB:RB_LSB];
   assign rc             = bus.ir[RC_MSB:RC_LSB];
   assign unused_ir_bits = ^bus.ir[RC_LSB-1:0];
   assign op_class       = classify(opcode);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg <= ST_RST;
      end else begin
         case (state_reg)
            ST_RST: state_reg <= ST_T0;
            ST_T0:  state_reg <= ST_T1;
            ST_T1:  state_reg <= ST_T2;
            ST_T2:  state_reg <= ST_T3;
            ST_T3: begin
               if (op_class == CLS_HALT)
                  state_reg <= ST_HALTED;
               else if (op_class == CLS_NOP)
                  state_reg <= ST_T0;
               else
                  state_reg <= ST_T4;
            end
            ST_T4:     state_reg <= (op_class == CLS_UNARY) ? ST_T0 : ST_T5;
            ST_T5:     state_reg <= (op_class == CLS_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:     state_reg <= ST_T0;
            ST_HALTED: state_reg <= ST_HALTED;
            default:   state_reg <= ST_RST;
         endcase
      end
   end

   always_comb begin
      bus.pc_out  = 1'b0;
      bus.pc_in   = 1'b0;
      bus.inc_pc  = 1'b0;
      bus.mar_in  = 1'b0;
      bus.mdr_in  = 1'b0;
      bus.mdr_out = 1'b0;
      bus.read    = 1'b0;
      bus.ir_in   = 1'b0;
      bus.y_in    = 1'b0;
      bus.z_in    = 1'b0;
      bus.zlo_in  = 1'b0;
      bus.zhi_in  = 1'b0;
      bus.zlo_out = 1'b0;
      bus.zhi_out = 1'b0;
      bus.hi_in   = 1'b0;
      bus.lo_in   = 1'b0;
      bus.c_out   = 1'b0;
      bus.run     = 1'b1;
      rout_en     = 1'b0;
      rout_sel    = rb;
      rin_en      = 1'b0;
      alu_en      = 1'b0;

      case (state_reg)
         ST_T0: begin
            bus.pc_out = 1'b1;
            bus.mar_in = 1'b1;
            bus.inc_pc = 1'b1;
            bus.z_in   = 1'b1;
            bus.zlo_in = 1'b1;
         end
         ST_T1: begin
            bus.zlo_out = 1'b1;
            bus.pc_in   = 1'b1;
            bus.read    = 1'b1;
            bus.mdr_in  = 1'b1;
         end
         ST_T2: begin
            bus.mdr_out = 1'b1;
            bus.ir_in   = 1'b1;
         end
         ST_T3: begin
            case (op_class)
               CLS_RTYPE, CLS_IMM: begin
                  rout_en  = 1'b1;
                  bus.y_in = 1'b1;
               end
               CLS_UNARY: begin
                  rout_en    = 1'b1;
                  alu_en     = 1'b1;
                  bus.z_in   = 1'b1;
                  bus.zlo_in = 1'b1;
               end
               CLS_MULDIV: begin
                  rout_en  = 1'b1;
                  rout_sel = ra;
                  bus.y_in = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            case (op_class)
               CLS_RTYPE: begin
                  rout_en    = 1'b1;
                  rout_sel   = rc;
                  alu_en     = 1'b1;
                  bus.z_in   = 1'b1;
                  bus.zlo_in = 1'b1;
               end
               CLS_IMM: begin
                  bus.c_out  = 1'b1;
                  alu_en     = 1'b1;
                  bus.z_in   = 1'b1;
                  bus.zlo_in = 1'b1;
               end
               CLS_UNARY: begin
                  bus.zlo_out = 1'b1;
                  rin_en      = 1'b1;
               end
               CLS_MULDIV: begin
                  rout_en    = 1'b1;
                  alu_en     = 1'b1;
                  bus.z_in   = 1'b1;
                  bus.zlo_in = 1'b1;
                  bus.zhi_in = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (op_class)
               CLS_RTYPE, CLS_IMM: begin
                  bus.zlo_out = 1'b1;
                  rin_en      = 1'b1;
               end
               CLS_MULDIV: begin
                  bus.zlo_out = 1'b1;
                  bus.lo_in   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            bus.zhi_out = 1'b1;
            bus.hi_in   = 1'b1;
         end
         ST_HALTED: bus.run = 1'b0;
         default: ;
      endcase

      bus.alu_sel = alu_en ? ALUSEL_W'(alu_code(opcode)) : '0;
   end

   // Destination is always Ra; the source field depends on the phase.
   reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
      .sel    (ra),
      .en     (rin_en),
      .onehot (bus.rin)
   );

   reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
      .sel    (rout_sel),
      .en     (rout_en),
      .onehot (bus.rout)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a per-instruction expected strobe
// trace is built from the instruction-class tables and compared every cycle.
module tb_control_sequencer;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  alu;
      logic [16:0] strb;
      logic        run;
   } snap_t;

   localparam logic [16:0] M_PC_OUT  = 17'h00001;
   localparam logic [16:0] M_PC_IN   = 17'h00002;
   localparam logic [16:0] M_INC_PC  = 17'h00004;
   localparam logic [16:0] M_MAR_IN  = 17'h00008;
   localparam logic [16:0] M_MDR_IN  = 17'h00010;
   localparam logic [16:0] M_MDR_OUT = 17'h00020;
   localparam logic [16:0] M_READ    = 17'h00040;
   localparam logic [16:0] M_IR_IN   = 17'h00080;
   localparam logic [16:0] M_Y_IN    = 17'h00100;
   localparam logic [16:0] M_Z_IN    = 17'h00200;
   localparam logic [16:0] M_ZLO_IN  = 17'h00400;
   localparam logic [16:0] M_ZHI_IN  = 17'h00800;
   localparam logic [16:0] M_ZLO_OUT = 17'h01000;
   localparam logic [16:0] M_ZHI_OUT = 17'h02000;
   localparam logic [16:0] M_HI_IN   = 17'h04000;
   localparam logic [16:0] M_LO_IN   = 17'h08000;
   localparam logic [16:0] M_C_OUT   = 17'h10000;

   logic clk = 1'b0;
   logic clr;

   control_sequencer_if #(.NREGS(16), .ALUSEL_W(5)) bus ();

   control_sequencer #(.NREGS(16), .ALUSEL_W(5)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_bad = 0;
   snap_t exp_q[$];

   function automatic snap_t observe();
      snap_t s;
      s.rin  = bus.rin;
      s.rout = bus.rout;
      s.alu  = bus.alu_sel;
      s.strb = {bus.c_out, bus.lo_in, bus.hi_in, bus.zhi_out, bus.zlo_out, bus.zhi_in,
                bus.zlo_in, bus.z_in, bus.y_in, bus.ir_in, bus.read, bus.mdr_out,
                bus.mdr_in, bus.mar_in, bus.inc_pc, bus.pc_in, bus.pc_out};
      s.run  = bus.run;
      return s;
   endfunction

   function automatic snap_t step(input logic [16:0] strb, input logic [15:0] rin,
                                  input logic [15:0] rout, input logic [4:0] alu);
      snap_t s;
      s.strb = strb;
      s.rin  = rin;
      s.rout = rout;
      s.alu  = alu;
      s.run  = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'($urandom)};
   endfunction

   // Expected trace from the instruction-class tables, fetch included.
   task automatic build_expected(input logic [31:0] ir);
      int          op;
      logic [15:0] oh_a;
      logic [15:0] oh_b;
      logic [15:0] oh_c;
      logic [4:0]  alu;
      op   = int'(ir[31:27]);
      oh_a = 16'h0001 << ir[26:23];
      oh_b = 16'h0001 << ir[22:19];
      oh_c = 16'h0001 << ir[18:15];
      exp_q.delete();
      exp_q.push_back(step(M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN | M_ZLO_IN, 16'h0, 16'h0, 5'd0));
      exp_q.push_back(step(M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN, 16'h0, 16'h0, 5'd0));
      exp_q.push_back(step(M_MDR_OUT | M_IR_IN, 16'h0, 16'h0, 5'd0));
      if (op >= 1 && op <= 8) begin
         exp_q.push_back(step(M_Y_IN, 16'h0, oh_b, 5'd0));
         exp_q.push_back(step(M_Z_IN | M_ZLO_IN, 16'h0, oh_c, 5'(op)));
         exp_q.push_back(step(M_ZLO_OUT, oh_a, 16'h0, 5'd0));
      end else if (op >= 13 && op <= 15) begin
         alu = (op == 13) ? 5'd1 : (op == 14) ? 5'd3 : 5'd4;
         exp_q.push_back(step(M_Y_IN, 16'h0, oh_b, 5'd0));
         exp_q.push_back(step(M_C_OUT | M_Z_IN | M_ZLO_IN, 16'h0, 16'h0, alu));
         exp_q.push_back(step(M_ZLO_OUT, oh_a, 16'h0, 5'd0));
      end else if (op == 11 || op == 12) begin
         exp_q.push_back(step(M_Z_IN | M_ZLO_IN, 16'h0, oh_b, 5'(op)));
         exp_q.push_back(step(M_ZLO_OUT, oh_a, 16'h0, 5'd0));
      end else if (op == 9 || op == 10) begin
         exp_q.push_back(step(M_Y_IN, 16'h0, oh_a, 5'd0));
         exp_q.push_back(step(M_Z_IN | M_ZLO_IN | M_ZHI_IN, 16'h0, oh_b, 5'(op)));
         exp_q.push_back(step(M_ZLO_OUT | M_LO_IN, 16'h0, 16'h0, 5'd0));
         exp_q.push_back(step(M_ZHI_OUT | M_HI_IN, 16'h0, 16'h0, 5'd0));
      end else begin
         exp_q.push_back(step(17'h0, 16'h0, 16'h0, 5'd0));
      end
   endtask

   // Caller guarantees the next rising edge enters T0.
   task automatic run_instr(input string name, input logic [31:0] ir);
      snap_t got;
      build_expected(ir);
      foreach (exp_q[i]) begin
         @(posedge clk);
         #1;
         if (i == 0) bus.ir = ir;
         got = observe();
         n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++;
            $display("FAIL %s cyc%0d: got rin=%h rout=%h alu=%b strb=%h run=%b, need rin=%h rout=%h alu=%b strb=%h run=%b",
                     name, i, got.rin, got.rout, got.alu, got.strb, got.run,
                     exp_q[i].rin, exp_q[i].rout, exp_q[i].alu, exp_q[i].strb, exp_q[i].run);
         end
      end
      $display("instr %-14s ir=%h cycles=%0d", name, ir, exp_q.size());
   endtask

   task automatic test_reset();
      snap_t got;
      snap_t idle;
      idle = step(17'h0, 16'h0, 16'h0, 5'd0);
      clr    = 1'b0;
      bus.ir = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      got = observe();
      n_cmp++;
      if (got !== idle) begin
         n_bad++;
         $display("FAIL reset_hold: got rin=%h rout=%h alu=%b strb=%h run=%b, need all zero run=1",
                  got.rin, got.rout, got.alu, got.strb, got.run);
      end
      @(negedge clk);
      clr = 1'b1;
      #1;
      got = observe();
      n_cmp++;
      if (got !== idle) begin
         n_bad++;
         $display("FAIL reset_release: got rin=%h rout=%h alu=%b strb=%h run=%b, need all zero run=1",
                  got.rin, got.rout, got.alu, got.strb, got.run);
      end
      $display("reset released");
   endtask

   task automatic test_sub();
      run_instr("sub", mk_ir(5'b00010, 4'd4, 4'd3, 4'd4));
   endtask

   task automatic test_addi();
      run_instr("addi", mk_ir(5'b01101, 4'd1, 4'd2, 4'($urandom)));
   endtask

   task automatic test_mul();
      run_instr("mul", mk_ir(5'b01001, 4'd5, 4'd6, 4'($urandom)));
      run_instr("div", mk_ir(5'b01010, 4'd0, 4'd15, 4'd7));
   endtask

   task automatic test_unary_and_edges();
      run_instr("neg", mk_ir(5'b01011, 4'd9, 4'd9, 4'd0));
      run_instr("not", mk_ir(5'b01100, 4'd0, 4'd15, 4'd3));
      run_instr("ori_r15", mk_ir(5'b01111, 4'd15, 4'd0, 4'd0));
      run_instr("andi", mk_ir(5'b01110, 4'd7, 4'd7, 4'd7));
      run_instr("nop", mk_ir(5'b11010, 4'd3, 4'd3, 4'd3));
      run_instr("illegal_1f", mk_ir(5'b11111, 4'd2, 4'd4, 4'd6));
      run_instr("illegal_00", mk_ir(5'b00000, 4'd1, 4'd1, 4'd1));
   endtask

   task automatic test_back_to_back();
      logic [4:0]  op;
      logic [31:0] ir;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) < 8) begin
            do op = 5'($urandom_range(1, 26));
            while (op > 5'd15 && op < 5'd26);
         end else begin
            do op = 5'($urandom);
            while ((op >= 5'd1 && op <= 5'd15) || op == 5'd26 || op == 5'd27);
         end
         ir = {op, 27'($urandom)};
         run_instr($sformatf("rand%0d_op%0d", n, op), ir);
      end
   endtask

   task automatic test_async_reset();
      snap_t       got;
      snap_t       idle;
      logic [31:0] ir;
      idle = step(17'h0, 16'h0, 16'h0, 5'd0);
      ir   = mk_ir(5'b00010, 4'd4, 4'd3, 4'd4);
      build_expected(ir);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) bus.ir = ir;
         got = observe();
         n_cmp++;
         if (got !== exp_q[i]) begin
            n_bad++;
            $display("FAIL async_pre cyc%0d: got rin=%h rout=%h alu=%b strb=%h, need rin=%h rout=%h alu=%b strb=%h",
                     i, got.rin, got.rout, got.alu, got.strb,
                     exp_q[i].rin, exp_q[i].rout, exp_q[i].alu, exp_q[i].strb);
         end
      end
      #2;
      clr = 1'b0;
      #1;
      got = observe();
      n_cmp++;
      if (got !== idle) begin
         n_bad++;
         $display("FAIL async_drop: got rin=%h rout=%h alu=%b strb=%h run=%b, need all zero run=1",
                  got.rin, got.rout, got.alu, got.strb, got.run);
      end
      @(posedge clk);
      #1;
      got = observe();
      n_cmp++;
      if (got !== idle) begin
         n_bad++;
         $display("FAIL async_hold: got rin=%h rout=%h alu=%b strb=%h run=%b, need all zero run=1",
                  got.rin, got.rout, got.alu, got.strb, got.run);
      end
      @(negedge clk);
      clr = 1'b1;
      $display("async reset mid-T4 of sub applied");
      run_instr("after_async", mk_ir(5'b00001, 4'($urandom), 4'($urandom), 4'($urandom)));
   endtask

   task automatic test_halt();
      snap_t got;
      snap_t halted;
      snap_t idle;
      idle       = step(17'h0, 16'h0, 16'h0, 5'd0);
      halted     = idle;
      halted.run = 1'b0;
      run_instr("halt", mk_ir(5'b11011, 4'd1, 4'd2, 4'd3));
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         bus.ir = 32'($urandom);
         got = observe();
         n_cmp++;
         if (got !== halted) begin
            n_bad++;
            $display("FAIL halted cyc%0d: got rin=%h rout=%h alu=%b strb=%h run=%b, need all zero run=0",
                     i, got.rin, got.rout, got.alu, got.strb, got.run);
         end
      end
      @(negedge clk);
      clr = 1'b0;
      #1;
      got = observe();
      n_cmp++;
      if (got !== idle) begin
         n_bad++;
         $display("FAIL halt_clear: got rin=%h rout=%h alu=%b strb=%h run=%b, need all zero run=1",
                  got.rin, got.rout, got.alu, got.strb, got.run);
      end
      @(negedge clk);
      clr = 1'b1;
      $display("halt cleared by reset pulse");
      run_instr("restart_nop", mk_ir(5'b11010, 4'd0, 4'd0, 4'd0));
   endtask

   initial begin
      test_reset();
      test_sub();
      test_addi();
      test_mul();
      test_unary_and_edges();
      test_back_to_back();
      test_async_reset();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
